// File: rtl/core_boot_ctrl.sv
// Boot/sequencing controller: streams a program image into MainMemory, then
// releases core reset after a hold window, runs for a cycle budget and halts.
// Define CHECKSUM_EN to add an image checksum check and an ERROR state.
module core_boot_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int RST_HOLD  = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  run_limit,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    input  logic [7:0]        ld_csum,
    output logic              ld_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_reset,
    output logic              core_mem_en,
    output logic              busy,
    output logic              halted,
    output logic              err_ovf,
    output logic              err_csum,
    output logic [ADDR_W:0]   byte_count,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
`ifdef CHECKSUM_EN
        S_ERROR,
`endif
        S_HALT
    } state_e;

    // Pointer carries one extra bit: once set, the image has run off the top of memory.
    localparam logic [ADDR_W:0]   PTR_BASE  = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [3:0]        HOLD_LAST = 4'(RST_HOLD - 1);

    state_e             state_q, state_d;
    logic [ADDR_W:0]    ptr_q, ptr_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [7:0]         mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]    byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]   cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0]   limit_q, limit_d;
    logic [3:0]         hold_cnt_q, hold_cnt_d;
    logic               err_ovf_q, err_ovf_d;
    logic               restart;
    logic [CNT_W-1:0]   cyc_inc;
`ifdef CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
    logic               err_csum_q, err_csum_d;
`else
    logic               csum_unused;
    assign csum_unused = ^ld_csum;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        byte_cnt_d  = byte_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;
        limit_d     = limit_q;
        hold_cnt_d  = hold_cnt_q;
        err_ovf_d   = err_ovf_q;
        cyc_inc     = cyc_cnt_q + CNT_W'(1);
`ifdef CHECKSUM_EN
        csum_d      = csum_q;
        err_csum_d  = err_csum_q;
        restart     = start && (state_q == S_IDLE || state_q == S_HALT || state_q == S_ERROR);
`else
        restart     = start && (state_q == S_IDLE || state_q == S_HALT);
`endif

        if (restart) begin
            state_d    = S_LOAD;
            ptr_d      = PTR_BASE;
            byte_cnt_d = '0;
            cyc_cnt_d  = '0;
            err_ovf_d  = 1'b0;
`ifdef CHECKSUM_EN
            csum_d     = '0;
            err_csum_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (ld_valid) begin
                        if (ptr_q[ADDR_W]) begin
                            err_ovf_d = 1'b1;
                        end else begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = ptr_q[ADDR_W-1:0];
                            mem_wdata_d = ld_data;
                            ptr_d       = ptr_q + (ADDR_W+1)'(1);
                        end
                        byte_cnt_d = byte_cnt_q + (ADDR_W+1)'(1);
                        hold_cnt_d = '0;
`ifdef CHECKSUM_EN
                        csum_d = csum_q + ld_data;
                        if (ld_last) begin
                            if (csum_d != ld_csum) begin
                                state_d    = S_ERROR;
                                err_csum_d = 1'b1;
                            end else begin
                                state_d = S_HOLD;
                            end
                        end
`else
                        if (ld_last) state_d = S_HOLD;
`endif
                    end
                end
                S_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = S_RUN;
                        limit_d = run_limit;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 4'd1;
                    end
                end
                S_RUN: begin
                    // Saturate at all-ones; a nonzero limit can never match the wrapped value.
                    if (cyc_cnt_q != '1) cyc_cnt_d = cyc_inc;
                    if (limit_q != '0 && cyc_inc == limit_q) state_d = S_HALT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= PTR_BASE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= ADDR_BASE;
            mem_wdata_q <= '0;
            byte_cnt_q  <= '0;
            cyc_cnt_q   <= '0;
            limit_q     <= '0;
            hold_cnt_q  <= '0;
            err_ovf_q   <= 1'b0;
`ifdef CHECKSUM_EN
            csum_q      <= '0;
            err_csum_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            byte_cnt_q  <= byte_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
            limit_q     <= limit_d;
            hold_cnt_q  <= hold_cnt_d;
            err_ovf_q   <= err_ovf_d;
`ifdef CHECKSUM_EN
            csum_q      <= csum_d;
            err_csum_q  <= err_csum_d;
`endif
        end
    end

    assign ld_ready    = (state_q == S_LOAD);
    assign core_reset  = (state_q != S_RUN);
    assign core_mem_en = (state_q == S_HOLD) || (state_q == S_RUN);
    assign busy        = (state_q == S_LOAD) || (state_q == S_HOLD) || (state_q == S_RUN);
    assign halted      = (state_q == S_HALT);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign err_ovf     = err_ovf_q;
    assign byte_count  = byte_cnt_q;
    assign cycle_count = cyc_cnt_q;
`ifdef CHECKSUM_EN
    assign err_csum    = err_csum_q;
`else
    assign err_csum    = 1'b0;
`endif

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Directed + randomized bench for core_boot_ctrl: default instance plus a
// small-memory instance (ADDR_W=4, BASE_ADDR=12) for the overflow case.
module tb_core_boot_ctrl;
    logic        clock = 0, reset = 1, start = 0, start_s = 0;
    logic [15:0] run_limit = 0;
    logic        ld_valid = 0, ld_last = 0;
    logic [7:0]  ld_data = 0, ld_csum = 0;

    logic        ld_ready, mem_we, core_reset, core_mem_en, busy, halted, err_ovf, err_csum;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [10:0] byte_count;
    logic [15:0] cycle_count;

    logic        s_ld_ready, s_mem_we, s_core_reset, s_core_mem_en, s_busy, s_halted, s_err_ovf, s_err_csum;
    logic [3:0]  s_mem_addr;
    logic [7:0]  s_mem_wdata;
    logic [4:0]  s_byte_count;
    logic [15:0] s_cycle_count;

    core_boot_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .run_limit(run_limit),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_csum(ld_csum),
        .ld_ready(ld_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_reset(core_reset), .core_mem_en(core_mem_en), .busy(busy), .halted(halted),
        .err_ovf(err_ovf), .err_csum(err_csum), .byte_count(byte_count), .cycle_count(cycle_count)
    );

    core_boot_ctrl #(.ADDR_W(4), .BASE_ADDR(12)) dut_s (
        .clock(clock), .reset(reset), .start(start_s), .run_limit(run_limit),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_csum(ld_csum),
        .ld_ready(s_ld_ready), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .core_reset(s_core_reset), .core_mem_en(s_core_mem_en), .busy(s_busy), .halted(s_halted),
        .err_ovf(s_err_ovf), .err_csum(s_err_csum), .byte_count(s_byte_count), .cycle_count(s_cycle_count)
    );

    always #5 clock = ~clock;

    // Observed memory writes and core-reset activity, sampled mid-cycle.
    int         wr_n = 0, lo_n = 0, hold_n = 0, s_wr_n = 0, s_lo_n = 0;
    logic [9:0] wa [0:511];
    logic [7:0] wd [0:511];
    logic [3:0] s_wa [0:63];
    logic [7:0] s_wd [0:63];

    always @(negedge clock) begin
        if (mem_we) begin
            if (wr_n < 512) begin
                wa[wr_n] <= mem_addr;
                wd[wr_n] <= mem_wdata;
            end
            wr_n <= wr_n + 1;
        end
        if (s_mem_we) begin
            if (s_wr_n < 64) begin
                s_wa[s_wr_n] <= s_mem_addr;
                s_wd[s_wr_n] <= s_mem_wdata;
            end
            s_wr_n <= s_wr_n + 1;
        end
        if (!core_reset) lo_n <= lo_n + 1;
        if (core_reset && core_mem_en) hold_n <= hold_n + 1;
        if (!s_core_reset) s_lo_n <= s_lo_n + 1;
    end

    int n_cmp = 0, n_bad = 0;
    logic [7:0] img [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse(input bit sdut);
        if (sdut) start_s = 1; else start = 1;
        tick(1);
        start = 0;
        start_s = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_core_reset"}, core_reset, 1);
        chk({tag, "_mem_en"}, core_mem_en, 0);
        chk({tag, "_ld_ready"}, ld_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_err_ovf"}, err_ovf, 0);
        chk({tag, "_err_csum"}, err_csum, 0);
        chk({tag, "_byte_count"}, byte_count, 0);
        chk({tag, "_cycle_count"}, cycle_count, 0);
    endtask

    // mode 0: valid every cycle, 1: toggle 1/0, 2: random gaps
    task automatic load(input bit sdut, input int mode);
        int i = 0;
        int cyc = 0;
        bit tog = 1;
        bit v, rdy;
        while (i < img.size() && cyc < 600) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = !tog;
            ld_valid = v;
            ld_data = img[i];
            ld_last = (i == img.size() - 1);
            rdy = sdut ? s_ld_ready : ld_ready;
            tick(1);
            if (v && rdy) i++;
            cyc++;
        end
        ld_valid = 0;
        ld_last = 0;
        chk("load_done", i, img.size());
    endtask

    // what 0: main halted, 1: main core released, 2: small halted
    task automatic wait_for(input int what, input int bound);
        bit ok = 0;
        for (int c = 0; c < bound; c++) begin
            ok = (what == 0) ? halted : (what == 1) ? !core_reset : s_halted;
            if (ok) break;
            tick(1);
        end
        chk($sformatf("wait_%0d", what), ok, 1);
    endtask

    // Reference: image byte k lands at address k of the default instance.
    task automatic chk_writes(input string tag, input int w0);
        chk({tag, "_nwr"}, wr_n - w0, img.size());
        for (int k = 0; k < img.size(); k++) begin
            chk($sformatf("%s_addr%0d", tag, k), wa[w0 + k], k);
            chk($sformatf("%s_data%0d", tag, k), wd[w0 + k], img[k]);
        end
    endtask

    initial begin
        int w0, l0, h0, lim, n;
        logic [7:0] t1 [16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h43, 8'h03, 8'h13,
                                8'h00, 8'h63, 8'h03, 8'hb3, 8'hff, 8'h9f, 8'hf2, 8'hef};

        tick(2);
        chk_reset("por");
        chk("por_s_mem_addr", s_mem_addr, 12);
        chk("por_s_core_reset", s_core_reset, 1);
        reset = 0;
        tick(1);

        // Fixed 16-byte image, limit 20
        img.delete();
        foreach (t1[k]) img.push_back(t1[k]);
        run_limit = 20;
        w0 = wr_n; l0 = lo_n; h0 = hold_n;
        pulse(0);
        chk("t1_busy", busy, 1);
        load(0, 0);
        wait_for(0, 100);
        chk_writes("t1", w0);
        chk("t1_bytes", byte_count, 16);
        chk("t1_cycles", cycle_count, 20);
        chk("t1_run_lo", lo_n - l0, 20);
        chk("t1_hold", hold_n - h0, 4);
        chk("t1_core_reset", core_reset, 1);
        chk("t1_mem_en", core_mem_en, 0);
        chk("t1_busy_done", busy, 0);
        chk("t1_ovf", err_ovf, 0);

        // Restart from HALT, toggled valid, random limit, start ignored during RUN
        lim = $urandom_range(5, 40);
        run_limit = 16'(lim);
        img.delete();
        repeat (16) img.push_back(8'($urandom));
        w0 = wr_n; l0 = lo_n;
        pulse(0);
        chk("t2_bytes_clr", byte_count, 0);
        chk("t2_cycles_clr", cycle_count, 0);
        chk("t2_ld_ready", ld_ready, 1);
        load(0, 1);
        wait_for(1, 50);
        tick(1);
        pulse(0);
        chk("t2_start_ign_rdy", ld_ready, 0);
        chk("t2_start_ign_run", core_reset, 0);
        wait_for(0, 100);
        chk_writes("t2", w0);
        chk("t2_bytes", byte_count, 16);
        chk("t2_cycles", cycle_count, lim);
        chk("t2_run_lo", lo_n - l0, lim);

        // Random gaps, unlimited run, then async reset mid-RUN
        n = $urandom_range(5, 30);
        run_limit = 0;
        img.delete();
        repeat (n) img.push_back(8'($urandom));
        w0 = wr_n;
        pulse(0);
        load(0, 2);
        wait_for(1, 40);
        tick(50);
        chk("t3_cycles", cycle_count, 50);
        chk("t3_still_run", core_reset, 0);
        chk_writes("t3", w0);
        chk("t3_bytes", byte_count, n);
        #2 reset = 1;
        #1 chk_reset("rst_run");
        w0 = wr_n;
        tick(3);
        reset = 0;
        tick(2);
        chk("rst_run_nowr", wr_n - w0, 0);

        // Async reset mid-LOAD
        pulse(0);
        ld_valid = 1;
        ld_data = 8'($urandom);
        tick(3);
        chk("t4_mid_we", mem_we, 1);
        #2 reset = 1;
        #1 chk_reset("rst_load");
        w0 = wr_n;
        tick(3);
        reset = 0;
        tick(3);
        ld_valid = 0;
        chk("rst_load_nowr", wr_n - w0, 0);
        chk("rst_load_rdy", ld_ready, 0);

        // Overflow on the small instance: 6 bytes from address 12
        run_limit = 3;
        img.delete();
        repeat (6) img.push_back(8'($urandom));
        w0 = s_wr_n; l0 = s_lo_n;
        pulse(1);
        load(1, 0);
        wait_for(2, 50);
        chk("ovf_nwr", s_wr_n - w0, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf_addr%0d", k), s_wa[w0 + k], 12 + k);
            chk($sformatf("ovf_data%0d", k), s_wd[w0 + k], img[k]);
        end
        chk("ovf_flag", s_err_ovf, 1);
        chk("ovf_bytes", s_byte_count, 6);
        chk("ovf_released", s_lo_n - l0, 3);
        chk("ovf_cycles", s_cycle_count, 3);
        chk("ovf_main_idle", busy, 0);

        // Checksum behaviour
        img.delete();
        img.push_back(8'h01); img.push_back(8'h02); img.push_back(8'h03);
        run_limit = 5;
`ifdef CHECKSUM_EN
        ld_csum = 8'h06;
        pulse(0);
        load(0, 0);
        wait_for(0, 40);
        chk("cs_ok_err", err_csum, 0);
        chk("cs_ok_cycles", cycle_count, 5);
        ld_csum = 8'h07;
        pulse(0);
        load(0, 0);
        tick(6);
        chk("cs_bad_err", err_csum, 1);
        chk("cs_bad_core_reset", core_reset, 1);
        chk("cs_bad_mem_en", core_mem_en, 0);
        chk("cs_bad_busy", busy, 0);
        chk("cs_bad_halted", halted, 0);
        pulse(0);
        chk("cs_restart_busy", busy, 1);
        chk("cs_restart_err", err_csum, 0);
        chk("cs_restart_rdy", ld_ready, 1);
        reset = 1;
        tick(1);
        reset = 0;
`else
        ld_csum = 8'h07;
        pulse(0);
        load(0, 0);
        wait_for(0, 40);
        chk("nocs_err", err_csum, 0);
        chk("nocs_halted", halted, 1);
        chk("nocs_cycles", cycle_count, 5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
